// File: rtl/ball_centroid_pkg.sv
// Shared constants for the ball centroid tracker.
// Frame geometry, accumulator widths and FSM encodings.
package ball_centroid_pkg;

   localparam logic [10:0] H_ACTIVE_DEF = 11'd640;
   localparam logic [10:0] V_ACTIVE_DEF = 11'd480;

   localparam int SUM_W = 28;
   localparam int CNT_W = 19;

   localparam logic [1:0] ST_ACCUM  = 2'b00;
   localparam logic [1:0] ST_DIVIDE = 2'b01;
   localparam logic [1:0] ST_UPDATE = 2'b10;

endpackage

// File: rtl/ball_centroid_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// done pulses exactly W cycles after the start cycle.
module seq_divider #(
   parameter int W = 28
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic         done,
   output logic         busy
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, quo_q, div_q;
   logic [W-1:0]  src_rem, src_quo, src_div;
   logic [W-1:0]  rem_d, quo_d;
   logic [W:0]    shifted;
   logic          ge;
   logic [CW-1:0] cnt_q;
   logic          busy_q, done_q;

   // The start cycle already performs the first iteration on the raw operands.
   always_comb begin
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      src_div = start ? divisor : div_q;
      shifted = {src_rem, src_quo[W-1]};
      ge      = shifted >= {1'b0, src_div};
      rem_d   = ge ? W'(shifted - {1'b0, src_div}) : shifted[W-1:0];
      quo_d   = {src_quo[W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= divisor;
            cnt_q  <= CW'(W - 1);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: rtl/ball_centroid.sv
// Per-frame colour-match centroid, presented as screen-centred
// signed coordinates that hold between frame updates.
module ball_centroid
   import ball_centroid_pkg::*;
#(
   parameter logic [10:0]      H_ACTIVE   = H_ACTIVE_DEF,
   parameter logic [10:0]      V_ACTIVE   = V_ACTIVE_DEF,
   parameter logic [CNT_W-1:0] MIN_PIXELS = 19'd16,
   parameter logic [3:0]       R_MIN      = 4'd8,
   parameter logic [3:0]       G_MAX      = 4'd4,
   parameter logic [3:0]       B_MAX      = 4'd4
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   input  logic [11:0] rgb,
   input  logic        vsync,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic        ball_valid,
   output logic        frame_done,
   output logic        busy,
   output logic        overrun
);

   logic             vsync_d_q;
   logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0] opx_q, opx_d, opy_q, opy_d;
   logic [CNT_W-1:0] opn_q, opn_d;
   logic [1:0]       state_q, state_d;
   logic             start_q, start_d;
   logic [10:0]      bx_q, bx_d, by_q, by_d;
   logic             bv_q, bv_d, fd_q, fd_d;
   logic             match, edge_e;
   logic [SUM_W-1:0] qx, qy;
   logic             dx_done, dy_done, dx_busy, dy_busy;
   logic             unused_div;

   assign match = pix_en && (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
                  && (rgb[11:8] >= R_MIN) && (rgb[7:4] <= G_MAX)
                  && (rgb[3:0] <= B_MAX);
   assign edge_e = vsync && !vsync_d_q;

   always_comb begin
      sum_x_d = sum_x_q;
      sum_y_d = sum_y_q;
      cnt_d   = cnt_q;
      opx_d   = opx_q;
      opy_d   = opy_q;
      opn_d   = opn_q;
      state_d = state_q;
      start_d = 1'b0;
      bx_d    = bx_q;
      by_d    = by_q;
      bv_d    = bv_q;
      fd_d    = 1'b0;
      // A frame edge always starts a fresh frame; a match on that cycle is lost.
      if (edge_e) begin
         sum_x_d = '0;
         sum_y_d = '0;
         cnt_d   = '0;
      end else if (match) begin
         sum_x_d = sum_x_q + SUM_W'(hcount);
         sum_y_d = sum_y_q + SUM_W'(vcount);
         cnt_d   = cnt_q + 1'b1;
      end
      unique case (state_q)
         ST_ACCUM: begin
            if (edge_e) begin
               opx_d = sum_x_q;
               opy_d = sum_y_q;
               opn_d = cnt_q;
               if (cnt_q >= MIN_PIXELS) begin
                  state_d = ST_DIVIDE;
                  start_d = 1'b1;
               end else begin
                  state_d = ST_UPDATE;
                  bv_d    = 1'b0;
                  fd_d    = 1'b1;
               end
            end
         end
         ST_DIVIDE: begin
            if (dx_done) begin
               state_d = ST_UPDATE;
               bx_d    = qx[10:0] - (H_ACTIVE >> 1);
               by_d    = qy[10:0] - (V_ACTIVE >> 1);
               bv_d    = 1'b1;
               fd_d    = 1'b1;
            end
         end
         ST_UPDATE: state_d = ST_ACCUM;
         default:   state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         vsync_d_q <= 1'b0;
         sum_x_q   <= '0;
         sum_y_q   <= '0;
         cnt_q     <= '0;
         opx_q     <= '0;
         opy_q     <= '0;
         opn_q     <= '0;
         state_q   <= ST_ACCUM;
         start_q   <= 1'b0;
         bx_q      <= '0;
         by_q      <= '0;
         bv_q      <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         vsync_d_q <= vsync;
         sum_x_q   <= sum_x_d;
         sum_y_q   <= sum_y_d;
         cnt_q     <= cnt_d;
         opx_q     <= opx_d;
         opy_q     <= opy_d;
         opn_q     <= opn_d;
         state_q   <= state_d;
         start_q   <= start_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         bv_q      <= bv_d;
         fd_q      <= fd_d;
      end
   end

   seq_divider #(.W(SUM_W)) u_div_x (
      .clk      (CLK100MHZ),
      .reset    (reset),
      .start    (start_q),
      .dividend (opx_q),
      .divisor  ({{(SUM_W-CNT_W){1'b0}}, opn_q}),
      .quotient (qx),
      .done     (dx_done),
      .busy     (dx_busy)
   );

   seq_divider #(.W(SUM_W)) u_div_y (
      .clk      (CLK100MHZ),
      .reset    (reset),
      .start    (start_q),
      .dividend (opy_q),
      .divisor  ({{(SUM_W-CNT_W){1'b0}}, opn_q}),
      .quotient (qy),
      .done     (dy_done),
      .busy     (dy_busy)
   );

   assign unused_div = ^{qx[SUM_W-1:11], qy[SUM_W-1:11],
                         dy_done, dx_busy, dy_busy};

   assign ball_x     = bx_q;
   assign ball_y     = by_q;
   assign ball_valid = bv_q;
   assign frame_done = fd_q;
   assign busy       = (state_q == ST_DIVIDE);
   assign overrun    = edge_e && (state_q != ST_ACCUM);

endmodule

// File: tb/tb_ball_centroid.sv
// Directed bench for ball_centroid with a frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_ball_centroid;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b0;
   logic        vsync = 1'b0;
   logic [10:0] hcount = '0;
   logic [10:0] vcount = '0;
   logic [11:0] rgb = '0;
   logic [10:0] ball_x, ball_y;
   logic        ball_valid, frame_done, busy, overrun;

   always #5 clk = ~clk;

   ball_centroid dut (
      .CLK100MHZ  (clk),
      .reset      (reset),
      .pix_en     (pix_en),
      .hcount     (hcount),
      .vcount     (vcount),
      .rgb        (rgb),
      .vsync      (vsync),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .ball_valid (ball_valid),
      .frame_done (frame_done),
      .busy       (busy),
      .overrun    (overrun)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic bit is_match(input logic en, input logic [10:0] h,
                                   input logic [10:0] v,
                                   input logic [11:0] c);
      return en && h < 640 && v < 480 && c[11:8] >= 8
             && c[7:4] <= 4 && c[3:0] <= 4;
   endfunction

   // Frame-level model: sums per frame, engine occupancy by cycle number.
   longint      sx, sy, n;
   longint      cyc = 0;
   longint      upd = -1;
   longint      blo = 1;
   longint      bhi = 0;
   bit          vs_prev = 0;
   bit          armed = 0;
   logic [10:0] ex = '0, ey = '0, px = '0, py = '0;
   bit          ev = 0, pv = 0;
   bit          edge_now, efd, eov, ebusy;

   task automatic model_clear();
      sx = 0; sy = 0; n = 0;
      vs_prev = 0;
      upd = -1; blo = 1; bhi = 0;
      ex = '0; ey = '0; ev = 0;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!armed) begin
         if (reset) begin
            armed = 1;
            model_clear();
         end
      end else begin
         edge_now = vsync && !vs_prev;
         efd = (cyc == upd);
         if (efd) begin
            ex = px; ey = py; ev = pv;
         end
         ebusy = (cyc >= blo) && (cyc <= bhi);
         eov = edge_now && (cyc <= upd);
         chk("frame_done", frame_done, efd);
         chk("busy", busy, ebusy);
         chk("overrun", overrun, eov);
         chk("ball_x", ball_x, ex);
         chk("ball_y", ball_y, ey);
         chk("ball_valid", ball_valid, ev);
         if (reset) begin
            model_clear();
         end else begin
            if (edge_now) begin
               if (cyc > upd) begin
                  if (n < 16) begin
                     px = ex; py = ey; pv = 0;
                     upd = cyc + 1;
                  end else begin
                     px = 11'(sx / n - 320);
                     py = 11'(sy / n - 240);
                     pv = 1;
                     upd = cyc + 30;
                     blo = cyc + 1;
                     bhi = cyc + 29;
                  end
               end
               sx = 0; sy = 0; n = 0;
            end else if (is_match(pix_en, hcount, vcount, rgb)) begin
               sx += hcount;
               sy += vcount;
               n++;
            end
            vs_prev = vsync;
         end
      end
   end

   task automatic tick(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pix(input int h, input int v, input logic [11:0] c);
      pix_en = 1'b1;
      hcount = 11'(h);
      vcount = 11'(v);
      rgb = c;
      tick();
      pix_en = 1'b0;
   endtask

   task automatic block(input int h0, input int v0, input int w,
                        input int ht, input logic [11:0] c);
      for (int v = v0; v < v0 + ht; v++)
         for (int h = h0; h < h0 + w; h++)
            pix(h, v, c);
   endtask

   task automatic edge_pulse();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
   endtask

   initial begin
      tick(2);
      reset = 1'b0;
      tick(3);
      chk("rst_x", ball_x, 0);
      chk("rst_valid", ball_valid, 0);
      chk("rst_busy", busy, 0);

      // empty frame takes the short path
      edge_pulse();
      chk("t1_fd", frame_done, 1);
      chk("t1_busy", busy, 0);
      tick(3);
      chk("t1_x", ball_x, 0);
      chk("t1_y", ball_y, 0);
      chk("t1_valid", ball_valid, 0);

      // 4x4 block at (100..103, 200..203)
      block(100, 200, 4, 4, 12'hF00);
      edge_pulse();
      chk("t2_busy_e1", busy, 1);
      tick(28);
      chk("t2_busy_e29", busy, 1);
      chk("t2_fd_e29", frame_done, 0);
      tick();
      chk("t2_fd", frame_done, 1);
      chk("t2_busy_e30", busy, 0);
      chk("t2_x", ball_x, 11'h725);
      chk("t2_y", ball_y, 11'h7D9);
      chk("t2_valid", ball_valid, 1);
      tick(3);

      // 10 matches including threshold corners, plus rejects
      block(10, 10, 4, 2, 12'hF00);
      pix(20, 20, 12'h844);
      pix(21, 20, 12'h844);
      pix(700, 20, 12'hF00);
      pix(30, 30, 12'h0F0);
      pix(31, 30, 12'h744);
      pix(32, 30, 12'h854);
      pix(33, 30, 12'h845);
      pix(34, 480, 12'hF00);
      pix_en = 1'b0;
      hcount = 11'd35;
      rgb = 12'hF00;
      tick();
      chk("t3_cnt_model", 32'(n), 10);
      edge_pulse();
      chk("t3_fd", frame_done, 1);
      chk("t3_valid", ball_valid, 0);
      chk("t3_x", ball_x, 11'h725);
      chk("t3_y", ball_y, 11'h7D9);
      tick(3);

      // full-width band centred vertically on the screen
      block(0, 208, 640, 64, 12'hF00);
      chk("t4_sumx_model", 32'(sx), 13086720);
      chk("t4_cnt_model", 32'(n), 40960);
      edge_pulse();
      tick(29);
      chk("t4_fd", frame_done, 1);
      chk("t4_x", ball_x, 11'h7FF);
      chk("t4_y", ball_y, 11'h7FF);
      chk("t4_valid", ball_valid, 1);
      tick(3);

      // second edge while dividing
      block(300, 100, 4, 4, 12'hF00);
      edge_pulse();
      block(0, 0, 3, 1, 12'hF00);
      tick(6);
      vsync = 1'b1;
      #1;
      chk("t5_ovr", overrun, 1);
      tick();
      vsync = 1'b0;
      #1;
      chk("t5_ovr_off", overrun, 0);
      block(400, 300, 4, 4, 12'hF00);
      tick(3);
      chk("t5_fd", frame_done, 1);
      chk("t5_x", ball_x, 11'h7ED);
      chk("t5_y", ball_y, 11'h775);
      tick(2);
      edge_pulse();
      tick(29);
      chk("t5b_fd", frame_done, 1);
      chk("t5b_x", ball_x, 11'h051);
      chk("t5b_y", ball_y, 11'h03D);
      tick(3);

      // reset during a divide
      block(50, 50, 4, 4, 12'hF00);
      edge_pulse();
      tick(14);
      chk("t6_busy_pre", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_x", ball_x, 0);
      chk("t6_y", ball_y, 0);
      chk("t6_valid", ball_valid, 0);
      tick(40);
      chk("t6_fd", frame_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
